// File: rtl/debug_slave_cmd_sync.sv
// debug_slave_cmd_sync: system-clock side of the JTAG debug slave.
// It brings the update-DR and update-IR strobes over from the tck domain.
// Each DR update captures {ir_in, sr} into a small command FIFO.
// The FIFO head is presented through a valid/ready handshake.
// Optional macro DEBUG_SLAVE_TIMEOUT_EN adds a handshake watchdog that discards a stalled head.
module debug_slave_cmd_sync #(
    parameter int IR_W        = 2,
    parameter int DR_W        = 38,
    parameter int ACT_BIT     = 35,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [IR_W-1:0]               ir_in,
    input  logic [DR_W-1:0]               sr,
    input  logic                          vs_udr,
    input  logic                          vs_uir,
    input  logic                          cmd_ready,
    input  logic                          overflow_clr,
    output logic                          cmd_valid,
    output logic [DR_W-1:0]               jdo,
    output logic [IR_W-1:0]               cmd_ir,
    output logic                          cmd_action,
    output logic                          uir_pulse,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          timeout_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = IR_W + DR_W;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_VALID = 1'b1;

    logic [SYNC_STAGES-1:0] r_udrSync;
    logic [SYNC_STAGES-1:0] r_uirSync;
    logic [SYNC_STAGES:0]   r_syncFill;
    logic                   r_udrPrev;
    logic                   r_uirPrev;
    logic                   r_uirPulse;
    logic [ENT_W-1:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_rdPtr;
    logic [PTR_W-1:0]       r_wrPtr;
    logic [LVL_W-1:0]       r_level;
    logic [0:0]             r_state;
    logic [ENT_W-1:0]       r_headData;
    logic                   r_overflow;

    logic                   w_syncLive;
    logic                   w_udrEvt;
    logic                   w_uirEvt;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;
    logic                   w_timeoutFire;
    logic [LVL_W-1:0]       w_levelNext;
    logic [PTR_W-1:0]       w_rdPtrNext;
    logic [ENT_W-1:0]       w_capture;

    // Edge detection is held off until the chains and edge registers carry real input samples.
    // This keeps a strobe that is already high at reset release from looking like a fresh rise.
    assign w_syncLive  = r_syncFill[SYNC_STAGES];
    assign w_udrEvt    = w_syncLive & r_udrSync[SYNC_STAGES-1] & ~r_udrPrev;
    assign w_uirEvt    = w_syncLive & r_uirSync[SYNC_STAGES-1] & ~r_uirPrev;

    assign w_capture   = {ir_in, sr};
    assign w_pop       = (r_state == ST_VALID) & (cmd_ready | w_timeoutFire);
    assign w_push      = w_udrEvt & ((r_level != LVL_FULL) | w_pop);
    assign w_drop      = w_udrEvt & (r_level == LVL_FULL) & ~w_pop;
    assign w_levelNext = r_level + LVL_W'(w_push) - LVL_W'(w_pop);
    assign w_rdPtrNext = r_rdPtr + PTR_W'(1);

    // Synchroniser chains, their edge-detect registers and the post-reset fill marker.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_udrSync  <= '0;
            r_uirSync  <= '0;
            r_syncFill <= '0;
            r_udrPrev  <= 1'b0;
            r_uirPrev  <= 1'b0;
            r_uirPulse <= 1'b0;
        end else begin
            r_udrSync  <= {r_udrSync[SYNC_STAGES-2:0], vs_udr};
            r_uirSync  <= {r_uirSync[SYNC_STAGES-2:0], vs_uir};
            r_syncFill <= {r_syncFill[SYNC_STAGES-1:0], 1'b1};
            r_udrPrev  <= r_udrSync[SYNC_STAGES-1];
            r_uirPrev  <= r_uirSync[SYNC_STAGES-1];
            r_uirPulse <= w_uirEvt;
        end
    end

    // FIFO storage. It needs no reset because the level and state decide what is visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= w_capture;
        end
    end

    // FIFO pointers and occupancy.
    // A push at full is only accepted when the same edge also pops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= w_rdPtrNext;
            end
            r_level <= w_levelNext;
        end
    end

    // Output FSM and the registered head copy.
    // When the last entry is popped while a new one is pushed, the new entry is forwarded from the capture bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_EMPTY;
            r_headData <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (r_level != '0) begin
                        r_state    <= ST_VALID;
                        r_headData <= r_mem[r_rdPtr];
                    end
                end
                ST_VALID: begin
                    if (w_pop) begin
                        if (w_levelNext == '0) begin
                            r_state <= ST_EMPTY;
                        end else if (r_level == LVL_ONE) begin
                            r_headData <= w_capture;
                        end else begin
                            r_headData <= r_mem[w_rdPtrNext];
                        end
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    // Sticky overflow flag. A drop on the same edge as a clear keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef DEBUG_SLAVE_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] r_toCnt;
    logic             r_timeoutErr;

    assign w_timeoutFire = (r_state == ST_VALID) & ~cmd_ready &
                           (r_toCnt == CNT_W'(TIMEOUT_CYC - 1));

    // Watchdog counter: counts stalled cycles of the current head and restarts on any pop or when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_toCnt <= '0;
        end else if ((r_state != ST_VALID) || cmd_ready || w_timeoutFire) begin
            r_toCnt <= '0;
        end else begin
            r_toCnt <= r_toCnt + CNT_W'(1);
        end
    end

    // Sticky watchdog flag. It shares the overflow clear, and a set on the same edge wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timeoutErr <= 1'b0;
        end else if (w_timeoutFire) begin
            r_timeoutErr <= 1'b1;
        end else if (overflow_clr) begin
            r_timeoutErr <= 1'b0;
        end
    end

    assign timeout_err = r_timeoutErr;
`else
    // Without the watchdog a stalled consumer back-pressures indefinitely.
    // TIMEOUT_CYC is still referenced so the parameter list stays identical across builds.
    assign w_timeoutFire = 1'b0;
    assign timeout_err   = (TIMEOUT_CYC > 0) ? 1'b0 : 1'b0;
`endif

    assign cmd_valid  = (r_state == ST_VALID);
    assign jdo        = r_headData[DR_W-1:0];
    assign cmd_ir     = r_headData[ENT_W-1:DR_W];
    assign cmd_action = r_headData[ACT_BIT];
    assign uir_pulse  = r_uirPulse;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_debug_slave_cmd_sync.sv
// tb_debug_slave_cmd_sync: scoreboard bench for debug_slave_cmd_sync.
// Stimulus pushes the expected commands into a queue.
// A negedge monitor pops and compares the queue whenever a handshake is about to complete.
// The DEBUG_SLAVE_TIMEOUT_EN macro selects the watchdog scenario.
module tb_debug_slave_cmd_sync;

    localparam int IR_W  = 2;
    localparam int DR_W  = 38;
    localparam int LVL_W = 3;

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [DR_W-1:0] sr;
        logic            act;
    } cmd_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [IR_W-1:0]  ir_in = '0;
    logic [DR_W-1:0]  sr = '0;
    logic             vs_udr = 1'b0;
    logic             vs_uir = 1'b0;
    logic             cmd_ready = 1'b0;
    logic             overflow_clr = 1'b0;
    logic             cmd_valid;
    logic [DR_W-1:0]  jdo;
    logic [IR_W-1:0]  cmd_ir;
    logic             cmd_action;
    logic             uir_pulse;
    logic [LVL_W-1:0] fifo_level;
    logic             overflow;
    logic             timeout_err;

    cmd_t expQ[$];
    cmd_t monHead;
    int   checkCount = 0;
    int   passCount = 0;

    debug_slave_cmd_sync #(
        .IR_W(IR_W), .DR_W(DR_W), .ACT_BIT(35), .SYNC_STAGES(2),
        .FIFO_DEPTH(4), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
        .vs_udr(vs_udr), .vs_uir(vs_uir), .cmd_ready(cmd_ready),
        .overflow_clr(overflow_clr), .cmd_valid(cmd_valid), .jdo(jdo),
        .cmd_ir(cmd_ir), .cmd_action(cmd_action), .uir_pulse(uir_pulse),
        .fifo_level(fifo_level), .overflow(overflow), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One DR update: strobe high for two cycles, then low long enough to re-arm edge detection.
    // clrAtDrop raises overflow_clr on the capture edge.
    task automatic applyStimulus(input logic [IR_W-1:0] irV, input logic [DR_W-1:0] srV,
                                 input logic actV, input bit kept, input bit clrAtDrop);
        ir_in  = irV;
        sr     = srV;
        vs_udr = 1'b1;
        if (kept) expQ.push_back('{ir: irV, sr: srV, act: actV});
        tick(2);
        vs_udr = 1'b0;
        overflow_clr = clrAtDrop;
        tick(1);
        overflow_clr = 1'b0;
        tick(2);
    endtask

    // Scoreboard monitor: a handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (reset_n && cmd_valid && cmd_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("pop with empty scoreboard", 64'(expQ.size()), 64'd1);
            end else begin
                monHead = expQ.pop_front();
                checkOutput("jdo", 64'(jdo), 64'(monHead.sr));
                checkOutput("cmd_ir", 64'(cmd_ir), 64'(monHead.ir));
                checkOutput("cmd_action", 64'(cmd_action), 64'(monHead.act));
            end
        end
    end

    // Global time limit so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL global timeout: got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    logic [DR_W-1:0] fillA [5] = '{38'h00_0000_0A01, 38'h08_0000_0A02, 38'h00_0000_0A03,
                                   38'h08_0000_0A04, 38'h00_0000_0A05};
    logic [DR_W-1:0] fillB [4] = '{38'h00_0000_0B01, 38'h00_0000_0B02, 38'h08_0000_0B03,
                                   38'h00_0000_0B04};

    initial begin
        int n;
        $display("[TB] start");
        tick(3);
        checkOutput("reset cmd_valid", 64'(cmd_valid), 64'd0);
        checkOutput("reset jdo", 64'(jdo), 64'd0);
        checkOutput("reset cmd_ir", 64'(cmd_ir), 64'd0);
        checkOutput("reset cmd_action", 64'(cmd_action), 64'd0);
        checkOutput("reset uir_pulse", 64'(uir_pulse), 64'd0);
        checkOutput("reset fifo_level", 64'(fifo_level), 64'd0);
        checkOutput("reset overflow", 64'(overflow), 64'd0);
        checkOutput("reset timeout_err", 64'(timeout_err), 64'd0);
        reset_n = 1'b1;
        tick(5);

        // Latency: cmd_valid first seen after the fourth edge that samples vs_udr high.
        ir_in  = 2'b01;
        sr     = 38'h20_0000_1234;
        vs_udr = 1'b1;
        expQ.push_back('{ir: 2'b01, sr: 38'h20_0000_1234, act: 1'b0});
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            if (i == 2) vs_udr = 1'b0;
            checkOutput($sformatf("latency valid edge %0d", i), 64'(cmd_valid), 64'(i == 4));
        end
        checkOutput("first jdo", 64'(jdo), 64'h20_0000_1234);
        checkOutput("first cmd_ir", 64'(cmd_ir), 64'd1);
        checkOutput("first cmd_action", 64'(cmd_action), 64'd0);
        cmd_ready = 1'b1;
        tick(1);
        checkOutput("valid after pop", 64'(cmd_valid), 64'd0);
        checkOutput("hold jdo when empty", 64'(jdo), 64'h20_0000_1234);

        // Action bit and IR 2.
        applyStimulus(2'b10, 38'h08_0000_0000, 1'b1, 1'b1, 1'b0);
        tick(1);
        checkOutput("valid after action pop", 64'(cmd_valid), 64'd0);
        cmd_ready = 1'b0;

        // Overflow: five updates into a four-entry FIFO, and the fifth drop coincides with a clear.
        for (int i = 0; i < 4; i++) applyStimulus(2'b11, fillA[i], fillA[i][35], 1'b1, 1'b0);
        checkOutput("level full", 64'(fifo_level), 64'd4);
        checkOutput("no overflow yet", 64'(overflow), 64'd0);
        applyStimulus(2'b11, fillA[4], 1'b0, 1'b0, 1'b1);
        checkOutput("overflow set wins over clear", 64'(overflow), 64'd1);
        checkOutput("level after drop", 64'(fifo_level), 64'd4);
        checkOutput("head stable while stalled", 64'(jdo), 64'(fillA[0]));
        cmd_ready = 1'b1;
        tick(6);
        cmd_ready = 1'b0;
        checkOutput("level drained", 64'(fifo_level), 64'd0);
        checkOutput("overflow sticky", 64'(overflow), 64'd1);
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        checkOutput("overflow cleared", 64'(overflow), 64'd0);

        // Push and pop on the same edge while full.
        for (int i = 0; i < 4; i++) applyStimulus(2'b00, fillB[i], fillB[i][35], 1'b1, 1'b0);
        ir_in  = 2'b01;
        sr     = 38'h08_0000_0C0C;
        vs_udr = 1'b1;
        expQ.push_back('{ir: 2'b01, sr: 38'h08_0000_0C0C, act: 1'b1});
        tick(2);
        vs_udr    = 1'b0;
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        checkOutput("level full push+pop", 64'(fifo_level), 64'd4);
        checkOutput("no overflow push+pop", 64'(overflow), 64'd0);
        cmd_ready = 1'b1;
        tick(6);
        cmd_ready = 1'b0;
        checkOutput("level drained 2", 64'(fifo_level), 64'd0);

        // uir_pulse: rises after the third edge and lasts exactly one cycle.
        vs_uir = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            if (i == 2) vs_uir = 1'b0;
            checkOutput($sformatf("uir_pulse edge %0d", i), 64'(uir_pulse), 64'(i == 3));
        end
        checkOutput("level after uir", 64'(fifo_level), 64'd0);

        // Asynchronous reset with three entries queued, while vs_udr stays high.
        for (int i = 0; i < 3; i++) applyStimulus(2'b10, fillA[i], fillA[i][35], 1'b0, 1'b0);
        checkOutput("level three", 64'(fifo_level), 64'd3);
        vs_udr = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async reset valid", 64'(cmd_valid), 64'd0);
        checkOutput("async reset level", 64'(fifo_level), 64'd0);
        tick(2);
        reset_n = 1'b1;
        tick(8);
        checkOutput("no event from held vs_udr", 64'(fifo_level), 64'd0);
        checkOutput("no valid from held vs_udr", 64'(cmd_valid), 64'd0);
        vs_udr = 1'b0;
        tick(3);
        cmd_ready = 1'b1;
        applyStimulus(2'b01, 38'h00_0000_0D0D, 1'b0, 1'b1, 1'b0);
        tick(1);
        cmd_ready = 1'b0;
        checkOutput("valid after recovery pop", 64'(cmd_valid), 64'd0);

`ifdef DEBUG_SLAVE_TIMEOUT_EN
        // Watchdog with TIMEOUT_CYC=16: a stalled head is held for 16 cycles, then discarded.
        ir_in  = 2'b10;
        sr     = 38'h00_0000_0E0E;
        vs_udr = 1'b1;
        tick(2);
        vs_udr = 1'b0;
        n = 0;
        while (!cmd_valid && n < 10) begin
            tick(1);
            n++;
        end
        checkOutput("watchdog entry valid", 64'(cmd_valid), 64'd1);
        n = 0;
        while (cmd_valid && n < 40) begin
            tick(1);
            n++;
        end
        checkOutput("watchdog stall cycles", 64'(n), 64'd16);
        checkOutput("watchdog timeout_err", 64'(timeout_err), 64'd1);
        checkOutput("watchdog level", 64'(fifo_level), 64'd0);
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        checkOutput("timeout_err cleared", 64'(timeout_err), 64'd0);
`else
        // Without the watchdog a stalled head stays valid indefinitely.
        applyStimulus(2'b10, 38'h00_0000_0E0E, 1'b0, 1'b1, 1'b0);
        tick(40);
        n = 0;
        checkOutput("stalled head still valid", 64'(cmd_valid), 64'd1);
        checkOutput("no timeout_err", 64'(timeout_err), 64'd0);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        checkOutput("valid after late pop", 64'(cmd_valid), 64'(n));
`endif

        tick(2);
        checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/debug_slave_cmd_sync.md
Name: debug_slave_cmd_sync

Overview:
- System-clock side of the JTAG debug slave, generalised successor to the fixed 2-bit-IR/38-bit-DR sysclk block.
- Synchronises update-DR/update-IR strobes from the tck domain and captures the shift register plus IR into a small command FIFO.
- Presents each command to the CPU debug logic with a valid/ready handshake, with a decoded action/no-action flag.
- Adds overflow detection, which the previous generation lacks; there, back-to-back updates were silently lost.

Parameters:
- IR_W, 2, instruction register width.
- DR_W, 38, data register (sr/jdo) width.
- ACT_BIT, 35, index of the sr bit that selects action vs no-action; must be < DR_W.
- SYNC_STAGES, 2, synchroniser depth for vs_udr/vs_uir; legal range 2..4.
- FIFO_DEPTH, 4, command FIFO entries; power of two, 2..16.
- TIMEOUT_CYC, 1024, handshake watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ir_in  in  IR_W  IR value from the tck domain; quasi-static.
- sr  in  DR_W  shift register from the tck domain; quasi-static.
- vs_udr  in  1  update-DR level from the tck domain; asynchronous to clk.
- vs_uir  in  1  update-IR level from the tck domain; asynchronous to clk.
- cmd_ready  in  1  consumer accepts the head command.
- overflow_clr  in  1  clears the overflow flag.
- cmd_valid  out  1  head command present.
- jdo  out  DR_W  head command data.
- cmd_ir  out  IR_W  IR captured with the head command.
- cmd_action  out  1  jdo[ACT_BIT] of the head command.
- uir_pulse  out  1  one-cycle pulse per IR update.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy count.
- overflow  out  1  sticky flag: a command was dropped.
- timeout_err  out  1  sticky flag: the watchdog dropped a command.

Behaviour:
- Reset: all synchroniser flops, FIFO pointers and outputs are 0. cmd_valid, jdo, cmd_ir, cmd_action, uir_pulse, fifo_level, overflow and timeout_err all read 0.
- Synchronisers: vs_udr and vs_uir each pass through a SYNC_STAGES flop chain, followed by one edge-detect register.
- udr_evt: 1 for exactly one cycle on a 0->1 transition of the synchronised vs_udr. uir_evt is formed the same way from vs_uir.
- uir_pulse is uir_evt registered: it appears one cycle after uir_evt, lasts one cycle, and has no other effect.
- Input stability: the tck side holds sr and ir_in stable from vs_udr rising until SYNC_STAGES+3 clk cycles later.
- Capture: on udr_evt, {ir_in, sr} is sampled and pushed into the FIFO.
- Latency: with the FIFO empty, cmd_valid rises SYNC_STAGES+2 clk edges after the first edge that samples vs_udr high (4 edges at default).
- Output FSM, 2 states:
  - EMPTY: cmd_valid=0; jdo/cmd_ir/cmd_action hold the last popped values (0 after reset).
  - VALID: cmd_valid=1; jdo/cmd_ir/cmd_action show the FIFO head.
  - EMPTY->VALID when the level becomes nonzero.
  - VALID->EMPTY on a pop that leaves the level at 0.
- Handshake: a pop occurs on a clk edge where cmd_valid && cmd_ready. The next entry is visible the following cycle.
  - cmd_valid must not drop without a pop; the watchdog is the only exception.
  - Head data stays stable while cmd_valid && !cmd_ready.
- Push and pop on the same edge: allowed at any level, including full; fifo_level is unchanged.
- Full without a pop: a push is dropped, FIFO contents are untouched, and overflow is set to 1.
- overflow_clr clears overflow. If overflow_clr and a new drop occur on the same edge, the flag stays set (set wins).
- Pointers wrap modulo FIFO_DEPTH. fifo_level saturates at FIFO_DEPTH and never underflows.
- A reset assertion mid-transfer empties the FIFO immediately (asynchronous). Synchroniser chains clear, so a vs_udr still high after reset release produces no event until it falls and rises again.
- udr_evt and uir_evt are independent and may occur on the same cycle.

Optional Feature:
- Macro: DEBUG_SLAVE_TIMEOUT_EN.
- Defined: a counter increments each cycle cmd_valid && !cmd_ready, and resets on a pop or when cmd_valid=0.
  - When it reaches TIMEOUT_CYC-1, the head is discarded as if popped, timeout_err is set (sticky), and the counter returns to 0.
  - overflow_clr also clears timeout_err.
- Undefined: no counter is instantiated, timeout_err is tied to 0, and a stalled consumer back-pressures indefinitely.

Test Plan:
- Reset release, then vs_udr pulse with sr=38'h20_0000_1234 and ir_in=2'b01: cmd_valid=1 at edge 4; jdo=38'h20_0000_1234, cmd_ir=1, cmd_action=0; with cmd_ready=1, cmd_valid=0 the next cycle.
- sr=38'h08_0000_0000 (bit 35 set), ir_in=2'b10: cmd_action=1, cmd_ir=2.
- Five udr pulses with cmd_ready=0 and FIFO_DEPTH=4: fifo_level=4, overflow=1, and the first four sr values pop in order; pulse overflow_clr and overflow=0.
- Level 4 with cmd_ready=1 and a simultaneous udr_evt: level stays 4, no overflow, new entry last.
- vs_uir pulse: uir_pulse is high for exactly 1 cycle and fifo_level is unchanged; reset asserted with level=3 gives cmd_valid=0 and fifo_level=0 immediately.
- With DEBUG_SLAVE_TIMEOUT_EN and TIMEOUT_CYC=16, cmd_ready held 0 for one entry: after 16 cycles the entry is dropped, cmd_valid=0, timeout_err=1.
